spu_exec: RTL and testbench
===========================

Name: spu_exec

Overview:
Single-issue execute/writeback sequencer that sits directly upstream of the SPU register file. It accepts one decoded instruction per handshake and drives the register file's two read ports to fetch operands. It computes the ALU result, using an iterative shift-add path for multiply, and drives the register file write port to retire the result. Only one instruction is in flight at a time, so no hazard logic is needed.

Parameters:
ADDR, 4, register address width (register count = 2**ADDR)
WIDTH, 16, data width

Ports:
clk  input  1  clock, all state updates on rising edge
rst  input  1  asynchronous, active-low reset (0 = reset)
instr_valid  input  1  instruction present
instr_ready  output  1  block can accept an instruction
instr_op  input  3  opcode: 0 ADD, 1 SUB, 2 AND, 3 OR, 4 XOR, 5 SHL, 6 MUL, 7 MOV
instr_rd  input  ADDR  destination register
instr_rs1  input  ADDR  source register 1
instr_rs2  input  ADDR  source register 2
r1_en  output  1  register file port-1 read enable
r1_addr  output  ADDR  register file port-1 read address
r1_data  input  WIDTH  register file port-1 read data (combinational)
r2_en  output  1  register file port-2 read enable
r2_addr  output  ADDR  register file port-2 read address
r2_data  input  WIDTH  register file port-2 read data (combinational)
w_en  output  1  register file write enable
w_addr  output  ADDR  register file write address
w_data  output  WIDTH  register file write data
busy  output  1  instruction in flight (state != IDLE)
flag_z  output  1  last retired result was zero
flag_c  output  1  carry/borrow of last retired ADD/SUB

Behaviour:
- Reset (rst=0, asynchronous): state=IDLE, all captured fields, operands, result, counter, flag_z and flag_c = 0. Outputs: instr_ready=1, busy=0, r1_en=r2_en=w_en=0, addrs=0, w_data=0.
- A reset asserted mid-operation abandons the instruction. No write occurs.
- FSM states: IDLE, READ, EXEC, MUL, WB.
- IDLE: instr_ready=1. If instr_valid=1 at a clock edge, capture op/rd/rs1/rs2 and go to READ. instr_ready=0 in every other state.
- READ (1 cycle): r1_en=r2_en=1, r1_addr=rs1, r2_addr=rs2. Latch r1_data into opa and r2_data into opb at the edge. Go to MUL if op=6, otherwise go to EXEC.
- EXEC (1 cycle): register the result res and the flags, then go to WB.
  - ADD: res = opa+opb mod 2**WIDTH; c = carry out.
  - SUB: res = opa-opb mod 2**WIDTH; c = 1 when opa<opb (unsigned borrow).
  - AND/OR/XOR: bitwise; c = 0.
  - SHL: res = opa << opb[3:0]; bits shifted out are lost; c = 0.
  - MOV: res = opa; c = 0.
- MUL: shift-add over exactly WIDTH cycles using counter 0..WIDTH-1.
  - Each cycle: if multiplier LSB=1, acc += multiplicand. Then multiplicand <<= 1 and multiplier >>= 1.
  - res = low WIDTH bits of opa*opb (unsigned); c = 0.
  - On counter=WIDTH-1, register flags and go to WB.
- WB (1 cycle): w_en=1, w_addr=rd, w_data=res. Write commits at the edge leaving WB. Next state is IDLE.
- flag_z = (res==0) and flag_c are registered together with res. They hold until the next retire.
- Addresses outside their enable cycle hold their last value; enables are the only qualifiers.
- Latency, with instruction accepted at edge E:
  - non-MUL: READ cycle E..E+1, EXEC E+1..E+2, w_en high E+2..E+3, write at edge E+3; throughput 1 instruction per 4 cycles.
  - MUL: write at edge E+WIDTH+2; throughput 1 per WIDTH+3 cycles.
- Back-to-back dependent instructions are always correct. The write commits before IDLE, and the next READ occurs at least 2 edges later.
- rd may equal rs1/rs2. Operands are latched in READ, so the destination is overwritten only in WB.
- instr_valid while busy is ignored. Fields are not sampled, and the upstream must hold the instruction until instr_ready=1.

Test Plan:
- Reset/idle: hold rst=0 then release -> instr_ready=1, busy=0, w_en=0, flag_z=flag_c=0. Assert rst=0 in EXEC -> no w_en pulse, instr_ready=1 immediately.
- ADD carry: R1=16'hFFFF, R2=16'h0001, ADD rd=3 -> w_en on the 3rd cycle after accept, w_addr=3, w_data=16'h0000, flag_z=1, flag_c=1.
- SUB borrow and logic ops: R1=5, R2=7, SUB -> 16'hFFFE, flag_c=1. R1=16'hF0F0 and R2=16'h0FF0 give AND 16'h00F0, OR 16'hFFF0, XOR 16'hFF00, each with flag_c=0.
- MUL: R4=300, R5=300, MUL rd=6 -> w_data=16'h5F90 (90000 mod 65536 = 24464), write exactly 18 cycles after accept, busy=1 throughout.
- Dependency chain: MOV R2<-R1 (R1=9), then SHL R2 by R3 (R3=4) issued back-to-back -> R2=9, then R2=16'h0090. Verify no stale operand.
- Handshake: hold instr_valid=1 continuously with changing fields -> only fields present at instr_ready=1 edges are executed. Exactly one w_en pulse per accepted instruction.

Source files
------------

// File: rtl/spu_exec.sv
// Single-issue execute/writeback sequencer in front of the SPU register file.
// Reads two operands, runs the ALU (iterative shift-add multiply), writes one result.
module spu_exec #(
    parameter int unsigned ADDR  = 4,
    parameter int unsigned WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             instr_valid,
    output logic             instr_ready,
    input  logic [2:0]       instr_op,
    input  logic [ADDR-1:0]  instr_rd,
    input  logic [ADDR-1:0]  instr_rs1,
    input  logic [ADDR-1:0]  instr_rs2,
    output logic             r1_en,
    output logic [ADDR-1:0]  r1_addr,
    input  logic [WIDTH-1:0] r1_data,
    output logic             r2_en,
    output logic [ADDR-1:0]  r2_addr,
    input  logic [WIDTH-1:0] r2_data,
    output logic             w_en,
    output logic [ADDR-1:0]  w_addr,
    output logic [WIDTH-1:0] w_data,
    output logic             busy,
    output logic             flag_z,
    output logic             flag_c
);

    localparam int unsigned CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    localparam logic [2:0] OP_ADD = 3'd0;
    localparam logic [2:0] OP_SUB = 3'd1;
    localparam logic [2:0] OP_AND = 3'd2;
    localparam logic [2:0] OP_OR  = 3'd3;
    localparam logic [2:0] OP_XOR = 3'd4;
    localparam logic [2:0] OP_SHL = 3'd5;
    localparam logic [2:0] OP_MUL = 3'd6;

    typedef enum logic [2:0] {IDLE, READ, EXEC, MUL, WB} state_t;

    state_t           state, state_d;
    logic [2:0]       op;
    logic [ADDR-1:0]  rd, rs1, rs2;
    logic [WIDTH-1:0] opa, opb, acc, res;
    logic [CW-1:0]    cnt;
    logic [WIDTH-1:0] alu_res, acc_step;
    logic             alu_c;
    logic [WIDTH:0]   sum;
    logic             mul_last;

    assign r1_addr = rs1;
    assign r2_addr = rs2;
    assign w_data  = res;

    assign mul_last = (cnt == CW'(WIDTH - 1));

    // Next-state decode
    always_comb begin
        state_d = state;
        case (state)
            IDLE:    if (instr_valid) state_d = READ;
            READ:    state_d = (op == OP_MUL) ? MUL : EXEC;
            EXEC:    state_d = WB;
            MUL:     if (mul_last) state_d = WB;
            WB:      state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Single-cycle ALU plus one shift-add multiply step
    always_comb begin
        sum      = {1'b0, opa} + {1'b0, opb};
        alu_res  = '0;
        alu_c    = 1'b0;
        acc_step = acc + (opb[0] ? opa : '0);
        case (op)
            OP_ADD: begin alu_res = sum[WIDTH-1:0]; alu_c = sum[WIDTH]; end
            OP_SUB: begin alu_res = opa - opb; alu_c = (opa < opb); end
            OP_AND: alu_res = opa & opb;
            OP_OR:  alu_res = opa | opb;
            OP_XOR: alu_res = opa ^ opb;
            OP_SHL: alu_res = opa << opb[3:0];
            default: alu_res = opa;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state <= IDLE;
        else      state <= state_d;
    end

    // Handshake/port strobes registered from the next state
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            instr_ready <= 1'b1;
            busy        <= 1'b0;
            r1_en       <= 1'b0;
            r2_en       <= 1'b0;
            w_en        <= 1'b0;
        end else begin
            instr_ready <= (state_d == IDLE);
            busy        <= (state_d != IDLE);
            r1_en       <= (state_d == READ);
            r2_en       <= (state_d == READ);
            w_en        <= (state_d == WB);
        end
    end

    // Datapath; in MUL, opa/opb double as multiplicand/multiplier shifters
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            op     <= '0;
            rd     <= '0;
            rs1    <= '0;
            rs2    <= '0;
            opa    <= '0;
            opb    <= '0;
            acc    <= '0;
            res    <= '0;
            cnt    <= '0;
            w_addr <= '0;
            flag_z <= 1'b0;
            flag_c <= 1'b0;
        end else begin
            case (state)
                IDLE: if (instr_valid) begin
                    op  <= instr_op;
                    rd  <= instr_rd;
                    rs1 <= instr_rs1;
                    rs2 <= instr_rs2;
                end
                READ: begin
                    opa <= r1_data;
                    opb <= r2_data;
                    acc <= '0;
                    cnt <= '0;
                end
                EXEC: begin
                    res    <= alu_res;
                    flag_z <= (alu_res == '0);
                    flag_c <= alu_c;
                    w_addr <= rd;
                end
                MUL: begin
                    acc <= acc_step;
                    opa <= opa << 1;
                    opb <= opb >> 1;
                    cnt <= cnt + CW'(1);
                    if (mul_last) begin
                        res    <= acc_step;
                        flag_z <= (acc_step == '0);
                        flag_c <= 1'b0;
                        w_addr <= rd;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_spu_exec.sv
// Directed self-checking bench for spu_exec with a behavioural register file.
module tb_spu_exec;

    logic        clk = 1'b0;
    logic        rst;
    logic        instr_valid;
    logic        instr_ready;
    logic [2:0]  instr_op;
    logic [3:0]  instr_rd, instr_rs1, instr_rs2;
    logic        r1_en, r2_en, w_en;
    logic [3:0]  r1_addr, r2_addr, w_addr;
    logic [15:0] r1_data, r2_data, w_data;
    logic        busy, flag_z, flag_c;

    logic [15:0] rf [16];
    logic        pl_en;
    logic [3:0]  pl_addr;
    logic [15:0] pl_data;
    logic [3:0]  wlog [64];
    int          wcount = 0;
    int          cyc = 0;
    int          checks = 0;
    int          errors = 0;
    int          acc_cyc;
    int          busy_lo;
    int          base;

    spu_exec #(.ADDR(4), .WIDTH(16)) dut (
        .clk(clk), .rst(rst),
        .instr_valid(instr_valid), .instr_ready(instr_ready),
        .instr_op(instr_op), .instr_rd(instr_rd),
        .instr_rs1(instr_rs1), .instr_rs2(instr_rs2),
        .r1_en(r1_en), .r1_addr(r1_addr), .r1_data(r1_data),
        .r2_en(r2_en), .r2_addr(r2_addr), .r2_data(r2_data),
        .w_en(w_en), .w_addr(w_addr), .w_data(w_data),
        .busy(busy), .flag_z(flag_z), .flag_c(flag_c)
    );

    always #5 clk = ~clk;

    assign r1_data = rf[r1_addr];
    assign r2_data = rf[r2_addr];

    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (w_en) rf[w_addr] <= w_data;
        else if (pl_en) rf[pl_addr] <= pl_data;
    end

    always @(posedge clk) begin
        if (w_en && wcount < 64) begin
            wlog[wcount] = w_addr;
            wcount = wcount + 1;
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic preload(input logic [3:0] a, input logic [15:0] d);
        @(negedge clk);
        pl_en = 1'b1; pl_addr = a; pl_data = d;
        @(negedge clk);
        pl_en = 1'b0;
    endtask

    task automatic issue(input logic [2:0] op, input logic [3:0] rd,
                         input logic [3:0] rs1, input logic [3:0] rs2);
        int n;
        @(negedge clk);
        instr_valid = 1'b1; instr_op = op; instr_rd = rd; instr_rs1 = rs1; instr_rs2 = rs2;
        n = 0;
        while (!instr_ready && n < 40) begin @(negedge clk); n++; end
        @(posedge clk);
        #1;
        acc_cyc = cyc;
        instr_valid = 1'b0;
    endtask

    // Wait for the write-back strobe, then check latency, port values, flags and commit
    task automatic wait_wb(input string tag, input logic [3:0] ea, input logic [15:0] ed,
                           input int elat, input logic ez, input logic ec);
        int n;
        busy_lo = 0;
        n = 0;
        @(negedge clk);
        while (!w_en && n < 40) begin
            if (!busy) busy_lo++;
            @(negedge clk);
            n++;
        end
        chk({tag, "_wen"},  32'(w_en), 32'd1);
        chk({tag, "_lat"},  32'(cyc - acc_cyc), 32'(elat));
        chk({tag, "_addr"}, 32'(w_addr), 32'(ea));
        chk({tag, "_data"}, 32'(w_data), 32'(ed));
        chk({tag, "_z"},    32'(flag_z), 32'(ez));
        chk({tag, "_c"},    32'(flag_c), 32'(ec));
        @(posedge clk);
        #1;
        chk({tag, "_rf"},   32'(rf[ea]), 32'(ed));
        chk({tag, "_wen_off"}, 32'(w_en), 32'd0);
    endtask

    initial begin
        rst = 1'b0;
        instr_valid = 1'b0; instr_op = '0; instr_rd = '0; instr_rs1 = '0; instr_rs2 = '0;
        pl_en = 1'b0; pl_addr = '0; pl_data = '0;
        repeat (3) @(negedge clk);
        chk("rst_ready",  32'(instr_ready), 32'd1);
        chk("rst_busy",   32'(busy), 32'd0);
        chk("rst_wen",    32'(w_en), 32'd0);
        chk("rst_ren",    32'({r1_en, r2_en}), 32'd0);
        chk("rst_flags",  32'({flag_z, flag_c}), 32'd0);
        chk("rst_addrs",  32'({r1_addr, r2_addr, w_addr}), 32'd0);
        chk("rst_wdata",  32'(w_data), 32'd0);
        rst = 1'b1;
        @(negedge clk);
        chk("idle_ready", 32'(instr_ready), 32'd1);

        // ADD with carry out and zero result
        preload(4'd1, 16'hFFFF);
        preload(4'd2, 16'h0001);
        issue(3'd0, 4'd3, 4'd1, 4'd2);
        #1;
        chk("read_en",   32'({r1_en, r2_en, busy, instr_ready}), 32'b1110);
        chk("read_addr", 32'({r1_addr, r2_addr}), 32'h12);
        wait_wb("add", 4'd3, 16'h0000, 2, 1'b1, 1'b1);

        // SUB borrow
        preload(4'd1, 16'd5);
        preload(4'd2, 16'd7);
        issue(3'd1, 4'd4, 4'd1, 4'd2);
        wait_wb("sub", 4'd4, 16'hFFFE, 2, 1'b0, 1'b1);

        // Logic ops
        preload(4'd1, 16'hF0F0);
        preload(4'd2, 16'h0FF0);
        issue(3'd2, 4'd5, 4'd1, 4'd2);
        wait_wb("and", 4'd5, 16'h00F0, 2, 1'b0, 1'b0);
        issue(3'd3, 4'd5, 4'd1, 4'd2);
        wait_wb("or",  4'd5, 16'hFFF0, 2, 1'b0, 1'b0);
        issue(3'd4, 4'd5, 4'd1, 4'd2);
        wait_wb("xor", 4'd5, 16'hFF00, 2, 1'b0, 1'b0);

        // MUL 300*300 mod 2^16; strobe rises 17 edges after accept, write at the 18th
        preload(4'd4, 16'd300);
        preload(4'd5, 16'd300);
        issue(3'd6, 4'd6, 4'd4, 4'd5);
        wait_wb("mul", 4'd6, 16'h5F90, 17, 1'b0, 1'b0);
        chk("mul_busy", 32'(busy_lo), 32'd0);

        // Dependent chain: MOV R2<-R1, then SHL R2 by R3
        preload(4'd1, 16'd9);
        preload(4'd3, 16'd4);
        issue(3'd7, 4'd2, 4'd1, 4'd0);
        wait_wb("mov", 4'd2, 16'd9, 2, 1'b0, 1'b0);
        issue(3'd5, 4'd2, 4'd2, 4'd3);
        wait_wb("shl", 4'd2, 16'h0090, 2, 1'b0, 1'b0);

        // Reset during EXEC abandons the instruction
        preload(4'd7, 16'h1234);
        preload(4'd1, 16'hFFFF);
        preload(4'd2, 16'h0001);
        base = wcount;
        issue(3'd0, 4'd7, 4'd1, 4'd2);
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        #1;
        chk("arst_ready", 32'(instr_ready), 32'd1);
        chk("arst_busy",  32'(busy), 32'd0);
        chk("arst_wen",   32'(w_en), 32'd0);
        repeat (2) @(negedge clk);
        rst = 1'b1;
        repeat (5) @(negedge clk);
        chk("arst_nowrite", 32'(wcount - base), 32'd0);
        chk("arst_rf",      32'(rf[7]), 32'h1234);
        chk("arst_flags",   32'({flag_z, flag_c}), 32'd0);

        // Valid held high with changing fields: only steps 0 and 4 are accepted
        preload(4'd1, 16'd9);
        base = wcount;
        @(negedge clk);
        for (int k = 0; k < 8; k++) begin
            instr_valid = 1'b1;
            instr_op  = 3'd7;
            instr_rd  = 4'(8 + k);
            instr_rs1 = 4'd1;
            instr_rs2 = 4'd0;
            @(negedge clk);
        end
        instr_valid = 1'b0;
        repeat (6) @(negedge clk);
        chk("hs_count", 32'(wcount - base), 32'd2);
        chk("hs_rd0",   32'(wlog[base]), 32'd8);
        chk("hs_rd1",   32'(wlog[base + 1]), 32'd12);
        chk("hs_rf",    32'(rf[12]), 32'd9);
        chk("hs_idle",  32'({instr_ready, busy}), 32'b10);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
